id_ex_operand_stage: RTL and testbench

ID/EX pipeline register and operand-delivery stage for the 64-bit RISC-V pipeline. It captures decoded instruction fields at the clock edge and presents the ALU operands and `alu_op` in the following cycle. Operands are resolved through EX/MEM and MEM/WB forwarding. The block detects load-use hazards and inserts bubbles, and it sits directly upstream of the 64-bit ALU.

---
 rtl/id_ex_operand_stage_pkg.sv | 41 ++++
 rtl/id_ex_operand_stage_if.sv | 59 +++++
 rtl/id_ex_operand_stage_forward_unit.sv | 28 ++
 rtl/id_ex_operand_stage.sv | 111 +++++++++++
 tb/tb_id_ex_operand_stage.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_operand_stage_pkg.sv
// Shared types for the ID/EX operand stage: widths, ALU codes, forward selects.
// Optional build macro: ID_EX_FORWARDING_EN (enables EX/MEM and MEM/WB bypass).
package riscv_pkg;

    localparam int XLEN = 64;
    localparam int RA_W = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_SLL = 4'b1111;

    typedef enum logic [1:0] {
        FWD_NONE,
        FWD_MEMWB,
        FWD_EXMEM
    } fwd_sel_e;

    typedef struct packed {
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic            alu_src;
        logic [3:0]      alu_op;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } id_ex_t;

    // True when a non-x0 destination is read by the decode-slot instruction
    function automatic logic rs_hit(input logic [RA_W-1:0] rd, rs1, rs2,
                                    input logic uses_rs2);
        return (rd != '0) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of decode, forwarding-source and EX-side signals of the operand stage.
// Optional build macro: ID_EX_FORWARDING_EN (memwb_* only consumed when defined).
interface id_ex_operand_stage_if;
    import riscv_pkg::*;

    logic            id_valid;
    logic            stall;
    logic            flush;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_alu_src;
    logic [3:0]      id_alu_op;
    logic            id_reg_write;
    logic            id_mem_read;
    logic            id_mem_write;
    logic            id_uses_rs2;
    logic            exmem_reg_write;
    logic [RA_W-1:0] exmem_rd;
    logic [XLEN-1:0] exmem_result;
    logic            memwb_reg_write;
    logic [RA_W-1:0] memwb_rd;
    logic [XLEN-1:0] memwb_result;

    logic            hazard_stall;
    logic            ex_valid;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] ex_store_data;
    logic [RA_W-1:0] ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;

    modport master (
        output id_valid, stall, flush, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_alu_src, id_alu_op,
               id_reg_write, id_mem_read, id_mem_write, id_uses_rs2,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  hazard_stall, ex_valid, alu_a, alu_b, alu_op,
               ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
    );

    modport slave (
        input  id_valid, stall, flush, id_rs1, id_rs2, id_rd,
               id_rs1_data, id_rs2_data, id_imm, id_alu_src, id_alu_op,
               id_reg_write, id_mem_read, id_mem_write, id_uses_rs2,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output hazard_stall, ex_valid, alu_a, alu_b, alu_op,
               ex_store_data, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write
    );

endinterface

// File: rtl/id_ex_operand_stage_forward_unit.sv
// Combinational bypass-source selection for the two registered operands.
// Only instantiated when ID_EX_FORWARDING_EN is defined.
module forward_unit
    import riscv_pkg::*;
(
    input  logic [RA_W-1:0] rs1_i,
    input  logic [RA_W-1:0] rs2_i,
    input  logic            exmem_reg_write_i,
    input  logic [RA_W-1:0] exmem_rd_i,
    input  logic            memwb_reg_write_i,
    input  logic [RA_W-1:0] memwb_rd_i,
    output fwd_sel_e        sel_a_o,
    output fwd_sel_e        sel_b_o
);

    // Younger producer (EX/MEM) shadows the older one; x0 never bypasses
    function automatic fwd_sel_e pick(input logic [RA_W-1:0] rs);
        if (exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs))
            return FWD_EXMEM;
        if (memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs))
            return FWD_MEMWB;
        return FWD_NONE;
    endfunction

    assign sel_a_o = pick(rs1_i);
    assign sel_b_o = pick(rs2_i);

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with load-use bubble insertion and operand delivery.
// Build macro ID_EX_FORWARDING_EN selects bypassing; otherwise RAW hits stall.
module id_ex_operand_stage
    import riscv_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    id_ex_operand_stage_if.slave io
);

    id_ex_t          stage_d, stage_q;
    logic            valid_d, valid_q;
    logic            load_use, raw_hit, hazard;
    logic [XLEN-1:0] rs1_fwd, rs2_fwd;

    always_comb begin
        load_use = io.id_valid & valid_q & stage_q.mem_read &
                   rs_hit(stage_q.rd, io.id_rs1, io.id_rs2, io.id_uses_rs2);
`ifdef ID_EX_FORWARDING_EN
        raw_hit = 1'b0;
`else
        // No bypass: any producer not yet in WB must drain first
        raw_hit = io.id_valid &
                  ((valid_q & stage_q.reg_write &
                    rs_hit(stage_q.rd, io.id_rs1, io.id_rs2, io.id_uses_rs2)) |
                   (io.exmem_reg_write &
                    rs_hit(io.exmem_rd, io.id_rs1, io.id_rs2, io.id_uses_rs2)));
`endif
        hazard = ~(io.stall | io.flush) & (load_use | raw_hit);
    end

    always_comb begin
        stage_d = stage_q;
        valid_d = valid_q;
        if (io.flush || hazard) begin
            valid_d           = 1'b0;
            stage_d.reg_write = 1'b0;
            stage_d.mem_read  = 1'b0;
            stage_d.mem_write = 1'b0;
        end else if (!io.stall) begin
            valid_d           = io.id_valid;
            stage_d.rs1       = io.id_rs1;
            stage_d.rs2       = io.id_rs2;
            stage_d.rd        = io.id_rd;
            stage_d.rs1_data  = io.id_rs1_data;
            stage_d.rs2_data  = io.id_rs2_data;
            stage_d.imm       = io.id_imm;
            stage_d.alu_src   = io.id_alu_src;
            stage_d.alu_op    = io.id_alu_op;
            stage_d.reg_write = io.id_reg_write & io.id_valid;
            stage_d.mem_read  = io.id_mem_read & io.id_valid;
            stage_d.mem_write = io.id_mem_write & io.id_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
            valid_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
        end
    end

`ifdef ID_EX_FORWARDING_EN
    fwd_sel_e sel_a, sel_b;

    forward_unit u_fwd (
        .rs1_i             (stage_q.rs1),
        .rs2_i             (stage_q.rs2),
        .exmem_reg_write_i (io.exmem_reg_write),
        .exmem_rd_i        (io.exmem_rd),
        .memwb_reg_write_i (io.memwb_reg_write),
        .memwb_rd_i        (io.memwb_rd),
        .sel_a_o           (sel_a),
        .sel_b_o           (sel_b)
    );

    function automatic logic [XLEN-1:0] pick(input fwd_sel_e sel,
                                             input logic [XLEN-1:0] rv, exm, mwb);
        unique case (sel)
            FWD_EXMEM: return exm;
            FWD_MEMWB: return mwb;
            default:   return rv;
        endcase
    endfunction

    assign rs1_fwd = pick(sel_a, stage_q.rs1_data, io.exmem_result, io.memwb_result);
    assign rs2_fwd = pick(sel_b, stage_q.rs2_data, io.exmem_result, io.memwb_result);
`else
    logic unused_fwd;

    assign rs1_fwd    = stage_q.rs1_data;
    assign rs2_fwd    = stage_q.rs2_data;
    assign unused_fwd = ^{io.exmem_result, io.memwb_reg_write, io.memwb_rd,
                          io.memwb_result, stage_q.rs1, stage_q.rs2};
`endif

    assign io.hazard_stall  = hazard;
    assign io.ex_valid      = valid_q;
    assign io.alu_a         = rs1_fwd;
    assign io.alu_b         = stage_q.alu_src ? stage_q.imm : rs2_fwd;
    assign io.ex_store_data = rs2_fwd;
    assign io.alu_op        = stage_q.alu_op;
    assign io.ex_rd         = stage_q.rd;
    assign io.ex_reg_write  = valid_q & stage_q.reg_write;
    assign io.ex_mem_read   = valid_q & stage_q.mem_read;
    assign io.ex_mem_write  = valid_q & stage_q.mem_write;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus
// randomized traffic against a slot-level reference model.
module tb_id_ex_operand_stage;
    import riscv_pkg::*;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    id_ex_operand_stage_if io ();

    id_ex_operand_stage dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: contents of the EX slot
    logic        m_valid;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [63:0] m_d1, m_d2, m_imm;
    logic        m_src;
    logic [3:0]  m_op;
    logic        m_rw, m_mr, m_mw;

    task automatic model_reset();
        m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_d1 = 0; m_d2 = 0; m_imm = 0; m_src = 0; m_op = 0;
        m_rw = 0; m_mr = 0; m_mw = 0;
    endtask

    function automatic logic reads(input logic [4:0] r);
        return (r != 5'd0) &&
               ((r == io.id_rs1) || (io.id_uses_rs2 && (r == io.id_rs2)));
    endfunction

    function automatic logic exp_hazard();
        if (io.stall || io.flush || !io.id_valid) return 1'b0;
        if (m_valid && m_mr && reads(m_rd)) return 1'b1;
`ifndef ID_EX_FORWARDING_EN
        if (m_valid && m_rw && reads(m_rd)) return 1'b1;
        if (io.exmem_reg_write && reads(io.exmem_rd)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [63:0] exp_fwd(input logic [4:0] r, input logic [63:0] d);
`ifdef ID_EX_FORWARDING_EN
        if (r != 5'd0) begin
            if (io.exmem_reg_write && io.exmem_rd == r) return io.exmem_result;
            if (io.memwb_reg_write && io.memwb_rd == r) return io.memwb_result;
        end
`endif
        return d;
    endfunction

    task automatic model_edge();
        logic h;
        h = exp_hazard();
        if (io.flush || (!io.stall && h)) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
        end else if (!io.stall) begin
            m_valid = io.id_valid;
            m_rs1 = io.id_rs1; m_rs2 = io.id_rs2; m_rd = io.id_rd;
            m_d1 = io.id_rs1_data; m_d2 = io.id_rs2_data; m_imm = io.id_imm;
            m_src = io.id_alu_src; m_op = io.id_alu_op;
            m_rw = io.id_reg_write; m_mr = io.id_mem_read; m_mw = io.id_mem_write;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        io.id_valid = 0; io.stall = 0; io.flush = 0;
        io.id_rs1 = 0; io.id_rs2 = 0; io.id_rd = 0;
        io.id_rs1_data = 0; io.id_rs2_data = 0; io.id_imm = 0;
        io.id_alu_src = 0; io.id_alu_op = 0;
        io.id_reg_write = 0; io.id_mem_read = 0; io.id_mem_write = 0;
        io.id_uses_rs2 = 0;
        io.exmem_reg_write = 0; io.exmem_rd = 0; io.exmem_result = 0;
        io.memwb_reg_write = 0; io.memwb_rd = 0; io.memwb_result = 0;
    endtask

    task automatic present(input logic [4:0] rs1, rs2, rd,
                           input logic [63:0] d1, d2, imm,
                           input logic src, input logic [3:0] op,
                           input logic rw, mr, mw, uses);
        io.id_valid = 1; io.id_rs1 = rs1; io.id_rs2 = rs2; io.id_rd = rd;
        io.id_rs1_data = d1; io.id_rs2_data = d2; io.id_imm = imm;
        io.id_alu_src = src; io.id_alu_op = op;
        io.id_reg_write = rw; io.id_mem_read = mr; io.id_mem_write = mw;
        io.id_uses_rs2 = uses;
    endtask

    task automatic drain();
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (io.ex_valid !== 1'b0 || io.alu_op !== 4'b0000 || io.ex_rd !== 5'd0) begin
            errors++;
            $display("FAIL reset_ctrl: valid=%b op=%b rd=%0d, want 0", io.ex_valid, io.alu_op, io.ex_rd);
        end
        checks++;
        if ({io.alu_a, io.alu_b, io.ex_store_data} !== '0) begin
            errors++;
            $display("FAIL reset_data: a=%h b=%h sd=%h, want 0", io.alu_a, io.alu_b, io.ex_store_data);
        end
        checks++;
        if ({io.ex_reg_write, io.ex_mem_read, io.ex_mem_write, io.hazard_stall} !== 4'b0) begin
            errors++;
            $display("FAIL reset_bits: rw/mr/mw/hz=%b, want 0000",
                     {io.ex_reg_write, io.ex_mem_read, io.ex_mem_write, io.hazard_stall});
        end
    endtask

    task automatic test_add();
        drain();
        present(5'd1, 5'd2, 5'd3, 64'd5, 64'd7, 64'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (io.hazard_stall !== 1'b0) begin
            errors++; $display("FAIL add_hazard: got %b want 0", io.hazard_stall);
        end
        tick();
        present(5'd9, 5'd3, 5'd4, 64'd1, 64'haa, 64'h123, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (io.alu_a !== 64'd5 || io.alu_b !== 64'd7 || io.ex_store_data !== 64'd7) begin
            errors++;
            $display("FAIL add_operands: a=%0d b=%0d sd=%0d want 5 7 7", io.alu_a, io.alu_b, io.ex_store_data);
        end
        checks++;
        if (io.alu_op !== ALU_ADD || io.ex_valid !== 1'b1 || io.ex_rd !== 5'd3 || io.ex_reg_write !== 1'b1) begin
            errors++;
            $display("FAIL add_ctrl: op=%b v=%b rd=%0d rw=%b want 0010 1 3 1",
                     io.alu_op, io.ex_valid, io.ex_rd, io.ex_reg_write);
        end
        checks++;
        if (io.hazard_stall !== 1'b0) begin
            errors++; $display("FAIL unused_rs2_hazard: got %b want 0", io.hazard_stall);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (io.alu_b !== 64'h123 || io.ex_store_data !== 64'haa || io.alu_a !== 64'd1) begin
            errors++;
            $display("FAIL imm_operand: a=%h b=%h sd=%h want 1 123 aa", io.alu_a, io.alu_b, io.ex_store_data);
        end
    endtask

    task automatic test_load_use();
        drain();
        present(5'd1, 5'd0, 5'd5, 64'h100, 64'd0, 64'd8, 1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        present(5'd5, 5'd1, 5'd6, 64'hdead, 64'd3, 64'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (io.hazard_stall !== 1'b1) begin
            errors++; $display("FAIL lu_hazard: got %b want 1", io.hazard_stall);
        end
        tick();
        io.exmem_reg_write = 1; io.exmem_rd = 5'd5; io.exmem_result = 64'h108;
        #1;
        checks++;
        if (io.ex_valid !== 1'b0 || io.ex_mem_read !== 1'b0) begin
            errors++; $display("FAIL lu_bubble: v=%b mr=%b want 0 0", io.ex_valid, io.ex_mem_read);
        end
`ifdef ID_EX_FORWARDING_EN
        checks++;
        if (io.hazard_stall !== 1'b0) begin
            errors++; $display("FAIL lu_single: got %b want 0", io.hazard_stall);
        end
        tick();
`else
        checks++;
        if (io.hazard_stall !== 1'b1) begin
            errors++; $display("FAIL lu_exmem_raw: got %b want 1", io.hazard_stall);
        end
        tick();
        io.id_rs1_data = 64'h55;
`endif
        io.exmem_reg_write = 0;
        io.memwb_reg_write = 1; io.memwb_rd = 5'd5; io.memwb_result = 64'h55;
`ifndef ID_EX_FORWARDING_EN
        #1;
        checks++;
        if (io.hazard_stall !== 1'b0 || io.ex_valid !== 1'b0) begin
            errors++; $display("FAIL lu_release: hz=%b v=%b want 0 0", io.hazard_stall, io.ex_valid);
        end
        tick();
        io.id_valid = 0;
`endif
        #1;
        checks++;
        if (io.ex_valid !== 1'b1 || io.alu_a !== 64'h55 || io.alu_b !== 64'd3) begin
            errors++;
            $display("FAIL lu_capture: v=%b a=%h b=%h want 1 55 3", io.ex_valid, io.alu_a, io.alu_b);
        end
    endtask

    task automatic test_stall_flush();
        drain();
        present(5'd1, 5'd2, 5'd7, 64'd11, 64'd22, 64'd0, 1'b0, ALU_OR, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        present(5'd3, 5'd4, 5'd0, 64'd1, 64'd2, 64'd16, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b1, 1'b1);
        io.stall = 1;
        #1;
        checks++;
        if (io.hazard_stall !== 1'b0) begin
            errors++; $display("FAIL stall_hazard: got %b want 0", io.hazard_stall);
        end
        tick();
        #1;
        checks++;
        if (io.ex_valid !== 1'b1 || io.ex_rd !== 5'd7 || io.alu_op !== ALU_OR ||
            io.alu_a !== 64'd11 || io.ex_mem_write !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: v=%b rd=%0d op=%b a=%0d mw=%b want 1 7 0001 11 0",
                     io.ex_valid, io.ex_rd, io.alu_op, io.alu_a, io.ex_mem_write);
        end
        io.flush = 1;
        tick();
        io.flush = 0;
        #1;
        checks++;
        if (io.ex_valid !== 1'b0 || io.ex_mem_write !== 1'b0 || io.ex_reg_write !== 1'b0) begin
            errors++;
            $display("FAIL stall_flush: v=%b mw=%b rw=%b want 0 0 0", io.ex_valid, io.ex_mem_write, io.ex_reg_write);
        end
        tick();
        #1;
        checks++;
        if (io.ex_valid !== 1'b0 || io.ex_mem_write !== 1'b0) begin
            errors++; $display("FAIL stall_after_flush: v=%b mw=%b want 0 0", io.ex_valid, io.ex_mem_write);
        end
        io.stall = 0;
    endtask

    task automatic test_back_to_back();
        drain();
        present(5'd1, 5'd0, 5'd2, 64'd10, 64'd0, 64'd1, 1'b1, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        present(5'd2, 5'd1, 5'd3, 64'd0, 64'd10, 64'd0, 1'b0, ALU_SUB, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef ID_EX_FORWARDING_EN
        #1;
        checks++;
        if (io.hazard_stall !== 1'b0) begin
            errors++; $display("FAIL b2b_hazard: got %b want 0", io.hazard_stall);
        end
        tick();
        io.id_valid = 0;
        io.exmem_reg_write = 1; io.exmem_rd = 5'd2; io.exmem_result = 64'd11;
`else
        #1;
        checks++;
        if (io.hazard_stall !== 1'b1) begin
            errors++; $display("FAIL b2b_bubble1: got %b want 1", io.hazard_stall);
        end
        tick();
        io.exmem_reg_write = 1; io.exmem_rd = 5'd2; io.exmem_result = 64'd11;
        #1;
        checks++;
        if (io.hazard_stall !== 1'b1 || io.ex_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_bubble2: hz=%b v=%b want 1 0", io.hazard_stall, io.ex_valid);
        end
        tick();
        io.exmem_reg_write = 0;
        io.memwb_reg_write = 1; io.memwb_rd = 5'd2; io.memwb_result = 64'd11;
        io.id_rs1_data = 64'd11;
        #1;
        checks++;
        if (io.hazard_stall !== 1'b0 || io.ex_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_release: hz=%b v=%b want 0 0", io.hazard_stall, io.ex_valid);
        end
        tick();
        io.id_valid = 0;
`endif
        #1;
        checks++;
        if (io.ex_valid !== 1'b1 || io.alu_a !== 64'd11 || io.alu_b !== 64'd10 || io.alu_op !== ALU_SUB) begin
            errors++;
            $display("FAIL b2b_sub: v=%b a=%0d b=%0d op=%b want 1 11 10 0110",
                     io.ex_valid, io.alu_a, io.alu_b, io.alu_op);
        end
    endtask

    task automatic test_forward();
        logic [63:0] want [4];
`ifdef ID_EX_FORWARDING_EN
        want = '{64'h10, 64'h20, 64'h20, 64'h1};
`else
        want = '{64'h1, 64'h1, 64'h1, 64'h1};
`endif
        drain();
        present(5'd4, 5'd0, 5'd9, 64'd1, 64'd0, 64'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        clear_inputs();
        io.exmem_reg_write = 1; io.exmem_rd = 5'd4; io.exmem_result = 64'h10;
        io.memwb_reg_write = 1; io.memwb_rd = 5'd4; io.memwb_result = 64'h20;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) io.exmem_reg_write = 0;
            if (k == 2) begin io.exmem_reg_write = 1; io.exmem_rd = 5'd0; end
            if (k == 3) io.memwb_rd = 5'd0;
            #1;
            checks++;
            if (io.alu_a !== want[k]) begin
                errors++; $display("FAIL fwd_step%0d: a=%h want %h", k, io.alu_a, want[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        drain();
        present(5'd1, 5'd0, 5'd5, 64'h7, 64'd0, 64'd8, 1'b1, ALU_SLL, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        present(5'd5, 5'd5, 5'd6, 64'd1, 64'd1, 64'd0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
        #2;
        reset = 1;
        #1;
        checks++;
        if (io.ex_valid !== 1'b0 || io.hazard_stall !== 1'b0 || io.alu_op !== 4'b0000 ||
            io.ex_rd !== 5'd0 || io.ex_mem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_ctrl: v=%b hz=%b op=%b rd=%0d mr=%b want all 0",
                     io.ex_valid, io.hazard_stall, io.alu_op, io.ex_rd, io.ex_mem_read);
        end
        checks++;
        if ({io.alu_a, io.alu_b, io.ex_store_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_data: a=%h b=%h sd=%h want 0", io.alu_a, io.alu_b, io.ex_store_data);
        end
        @(negedge clk);
        model_reset();
        clear_inputs();
        reset = 0;
    endtask

    task automatic test_random();
        logic [63:0] ea, eb, esd;
        drain();
        for (int n = 0; n < 400; n++) begin
            io.id_valid = ($urandom_range(0, 99) < 80);
            io.stall = ($urandom_range(0, 99) < 15);
            io.flush = ($urandom_range(0, 99) < 7);
            io.id_rs1 = 5'($urandom_range(0, 7));
            io.id_rs2 = 5'($urandom_range(0, 7));
            io.id_rd = 5'($urandom_range(0, 7));
            io.id_rs1_data = {$urandom(), $urandom()};
            io.id_rs2_data = {$urandom(), $urandom()};
            io.id_imm = {$urandom(), $urandom()};
            io.id_alu_src = 1'($urandom_range(0, 1));
            io.id_alu_op = 4'($urandom_range(0, 15));
            io.id_reg_write = 1'($urandom_range(0, 1));
            io.id_mem_read = ($urandom_range(0, 99) < 30);
            io.id_mem_write = 1'($urandom_range(0, 1));
            io.id_uses_rs2 = 1'($urandom_range(0, 1));
            io.exmem_reg_write = 1'($urandom_range(0, 1));
            io.exmem_rd = 5'($urandom_range(0, 7));
            io.exmem_result = {$urandom(), $urandom()};
            io.memwb_reg_write = 1'($urandom_range(0, 1));
            io.memwb_rd = 5'($urandom_range(0, 7));
            io.memwb_result = {$urandom(), $urandom()};
            #1;
            checks++;
            if (io.hazard_stall !== exp_hazard()) begin
                errors++; $display("FAIL rnd_hazard n=%0d: got %b want %b", n, io.hazard_stall, exp_hazard());
            end
            checks++;
            if ({io.ex_valid, io.ex_reg_write, io.ex_mem_read, io.ex_mem_write} !==
                {m_valid, m_valid & m_rw, m_valid & m_mr, m_valid & m_mw}) begin
                errors++;
                $display("FAIL rnd_ctrl n=%0d: got %b want %b", n,
                         {io.ex_valid, io.ex_reg_write, io.ex_mem_read, io.ex_mem_write},
                         {m_valid, m_valid & m_rw, m_valid & m_mr, m_valid & m_mw});
            end
            if (m_valid) begin
                ea = exp_fwd(m_rs1, m_d1);
                esd = exp_fwd(m_rs2, m_d2);
                eb = m_src ? m_imm : esd;
                checks++;
                if (io.alu_a !== ea || io.alu_b !== eb || io.ex_store_data !== esd) begin
                    errors++;
                    $display("FAIL rnd_data n=%0d: a=%h b=%h sd=%h want %h %h %h",
                             n, io.alu_a, io.alu_b, io.ex_store_data, ea, eb, esd);
                end
                checks++;
                if (io.alu_op !== m_op || io.ex_rd !== m_rd) begin
                    errors++;
                    $display("FAIL rnd_fields n=%0d: op=%b rd=%0d want %b %0d", n, io.alu_op, io.ex_rd, m_op, m_rd);
                end
            end
            tick();
        end
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        reset = 0;
        @(negedge clk);
        test_add();
        test_load_use();
        test_stall_flush();
        test_back_to_back();
        test_forward();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
